// File: rtl/multi_debounce_pkg.sv
// multi_debounce_pkg
// Shared definitions for the multi-channel debouncer:
//   state_t     - per-channel filter FSM encoding
//   safe_clog2  - counter width helper that never returns zero
//   max_int     - larger of two integers, for sizing shared counters
package multi_debounce_pkg;

  typedef enum logic [1:0] {
    S_IDLE0 = 2'd0,  // debounced level 0, input quiet
    S_WAIT1 = 2'd1,  // input went high, counting stable ticks
    S_HELD1 = 2'd2,  // debounced level 1, input quiet
    S_WAIT0 = 2'd3   // input went low, counting stable ticks
  } state_t;

  // Width able to hold values 0..value-1, but at least one bit so that
  // degenerate parameter values still give a legal vector.
  function automatic int safe_clog2(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_debounce_ch.sv
// debounce_ch
// One debouncer channel: input synchroniser, stable-tick filter FSM,
// auto-repeat scheduler and registered output strobes.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   tick        - one-cycle sample tick shared by all channels
//   btn_raw     - raw asynchronous button input, 1 = pressed
//   repeat_en   - auto-repeat enable, synchronous to clk
//   level       - debounced level
//   press       - one-cycle strobe on level 0->1
//   rel         - one-cycle strobe on level 1->0 ("release" is a reserved word)
//   rpt         - one-cycle auto-repeat strobe
module debounce_ch
  import multi_debounce_pkg::*;
#(
  parameter int STABLE_N    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);

  localparam int CNT_W  = safe_clog2(STABLE_N + 1);
  localparam int RCNT_W = safe_clog2(max_int(REPEAT_DLY, REPEAT_RATE) + 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;

  state_t            state, state_next;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic [RCNT_W-1:0] rcnt, rcnt_next, rcnt_inc, rcnt_limit;
  logic              first, first_next;
  logic              press_next, rel_next, rpt_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], btn_raw};
  end

  assign s = sync[SYNC_STAGES-1];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    rcnt_next  = rcnt;
    first_next = first;
    press_next = 1'b0;
    rel_next   = 1'b0;
    rpt_next   = 1'b0;
    rcnt_inc   = rcnt + RCNT_W'(1);
    // The first repeat waits the longer delay; later ones use the rate.
    rcnt_limit = first ? RCNT_W'(REPEAT_DLY) : RCNT_W'(REPEAT_RATE);

    case (state)
      S_IDLE0: begin
        rcnt_next = '0;
        if (s) begin
          state_next = S_WAIT1;
          cnt_next   = '0;
        end
      end
      S_WAIT1: begin
        // A drop back to 0 wins over a tick arriving in the same cycle.
        if (!s) begin
          state_next = S_IDLE0;
        end else if (tick) begin
          if (cnt == CNT_W'(STABLE_N - 1)) begin
            state_next = S_HELD1;
            press_next = 1'b1;
            rcnt_next  = '0;
            first_next = 1'b1;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      S_HELD1: begin
        if (!s) begin
          state_next = S_WAIT0;
          cnt_next   = '0;
        end else if (tick) begin
          if (rcnt_inc == rcnt_limit) begin
            // Schedule keeps running with repeat disabled; only the strobe is gated.
            rpt_next   = repeat_en;
            rcnt_next  = '0;
            first_next = 1'b0;
          end else begin
            rcnt_next = rcnt_inc;
          end
        end
      end
      S_WAIT0: begin
        // A bounce back to 1 resumes the hold with rcnt intact and no strobe.
        if (s) begin
          state_next = S_HELD1;
        end else if (tick) begin
          if (cnt == CNT_W'(STABLE_N - 1)) begin
            state_next = S_IDLE0;
            rel_next   = 1'b1;
            rcnt_next  = '0;
          end else begin
            cnt_next = cnt + CNT_W'(1);
          end
        end
      end
      default: state_next = S_IDLE0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE0;
      cnt   <= '0;
      rcnt  <= '0;
      first <= 1'b0;
      level <= 1'b0;
      press <= 1'b0;
      rel   <= 1'b0;
      rpt   <= 1'b0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      rcnt  <= rcnt_next;
      first <= first_next;
      level <= (state_next == S_HELD1) || (state_next == S_WAIT0);
      press <= press_next;
      rel   <= rel_next;
      rpt   <= rpt_next;
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// multi_debounce
// Multi-channel push-button debouncer: one shared sample-tick prescaler
// feeding N_CH independent debounce_ch instances.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   btn_raw     - [N_CH] raw asynchronous button inputs, 1 = pressed
//   repeat_en   - [N_CH] per-channel auto-repeat enable
//   level       - [N_CH] debounced level
//   press       - [N_CH] one-cycle strobe on level 0->1
//   rel         - [N_CH] one-cycle strobe on level 1->0 ("release" is reserved)
//   rpt         - [N_CH] one-cycle auto-repeat strobe
module multi_debounce
  import multi_debounce_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int TICK_DIV    = 1000000,
  parameter int STABLE_N    = 3,
  parameter int SYNC_STAGES = 2,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] btn_raw,
  input  logic [N_CH-1:0] repeat_en,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] rel,
  output logic [N_CH-1:0] rpt
);

  localparam int TICK_W = safe_clog2(TICK_DIV);

  logic [TICK_W-1:0] tick_cnt;
  logic              tick;

  assign tick = (tick_cnt == TICK_W'(TICK_DIV - 1));

  // Tick phase restarts at zero on every reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)     tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TICK_W'(1);
  end

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    debounce_ch #(
      .STABLE_N    (STABLE_N),
      .SYNC_STAGES (SYNC_STAGES),
      .REPEAT_DLY  (REPEAT_DLY),
      .REPEAT_RATE (REPEAT_RATE)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .btn_raw   (btn_raw[gi]),
      .repeat_en (repeat_en[gi]),
      .level     (level[gi]),
      .press     (press[gi]),
      .rel       (rel[gi]),
      .rpt       (rpt[gi])
    );
  end

endmodule

// File: tb/tb_multi_debounce.sv
// tb_multi_debounce
// Directed, table-driven bench for multi_debounce with a small parameter
// set (TICK_DIV=4, STABLE_N=3, REPEAT_DLY=2, REPEAT_RATE=1). Cycle numbers
// count posedges after reset release; ticks fall on cycles 4, 8, 12, ...
// The filter sees a raw level two cycles after it is sampled, so an input
// applied for cycle e reaches the FSM at cycle e+2.
module tb_multi_debounce;

  localparam int N_CH        = 2;
  localparam int TICK_DIV    = 4;
  localparam int STABLE_N    = 3;
  localparam int SYNC_STAGES = 2;
  localparam int REPEAT_DLY  = 2;
  localparam int REPEAT_RATE = 1;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N_CH-1:0] btn_raw = '0;
  logic [N_CH-1:0] repeat_en = '0;
  logic [N_CH-1:0] level, press, rel, rpt;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  multi_debounce #(
    .N_CH        (N_CH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_N    (STABLE_N),
    .SYNC_STAGES (SYNC_STAGES),
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_RATE (REPEAT_RATE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_raw   (btn_raw),
    .repeat_en (repeat_en),
    .level     (level),
    .press     (press),
    .rel       (rel),
    .rpt       (rpt)
  );

  typedef struct {
    bit         rst;  // reset the DUT before applying this entry
    int         n;    // cycles to hold inputs; outputs checked every cycle
    logic [1:0] btn;
    logic [1:0] en;
    logic [1:0] lvl;
    logic [1:0] prs;
    logic [1:0] rls;
    logic [1:0] rp;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit rst, input int n, input logic [1:0] btn,
                     input logic [1:0] en, input logic [1:0] lvl,
                     input logic [1:0] prs, input logic [1:0] rls,
                     input logic [1:0] rp, input string name);
    vec_t v;
    v.rst = rst; v.n = n; v.btn = btn; v.en = en;
    v.lvl = lvl; v.prs = prs; v.rls = rls; v.rp = rp; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic check2(input string name, input logic [1:0] act,
                        input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%b want=%b", name, cyc, act, exp);
    end
  endtask

  task automatic check_all(input string name, input logic [1:0] lvl,
                           input logic [1:0] prs, input logic [1:0] rls,
                           input logic [1:0] rp);
    check2({name, ".level"}, level, lvl);
    check2({name, ".press"}, press, prs);
    check2({name, ".release"}, rel, rls);
    check2({name, ".rpt"}, rpt, rp);
  endtask

  // Apply inputs for n cycles, checking outputs just after each posedge.
  task automatic run_vec(input int n, input logic [1:0] btn,
                         input logic [1:0] en, input logic [1:0] lvl,
                         input logic [1:0] prs, input logic [1:0] rls,
                         input logic [1:0] rp, input string name);
    int start;
    start = cyc + 1;
    for (int j = 0; j < n; j++) begin
      btn_raw   = btn;
      repeat_en = en;
      @(posedge clk);
      #1;
      cyc++;
      check_all(name, lvl, prs, rls, rp);
    end
    $display("vec %-14s cycles %0d..%0d btn=%b en=%b exp lvl=%b prs=%b rel=%b rpt=%b",
             name, start, cyc, btn, en, lvl, prs, rls, rp);
  endtask

  // Leaves reset released 1 time unit after a posedge: next edge is cycle 1.
  task automatic do_reset();
    reset     = 1'b1;
    btn_raw   = '0;
    repeat_en = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    // Clean press on ch0, held 40 cycles; s=1 from cycle 2, WAIT1 at 3,
    // ticks 4/8/12 -> accepted at 12. Then a 5-cycle low glitch (WAIT0 at
    // 43, one tick, bounce back at 48) and a stable low released at 64.
    add(1, 11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "press_wait");
    add(0,  1, 2'b01, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, "press_edge");
    add(0, 28, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, "press_hold");
    add(0,  5, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, "glitch_low");
    add(0,  7, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, "glitch_back");
    add(0, 11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, "release_wait");
    add(0,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "release_edge");
    add(0,  6, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "release_idle");
    // Bounce: toggle every 3 cycles, never long enough for 3 ticks.
    for (int k = 0; k < 5; k++) begin
      add(k == 0, 3, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_hi");
      add(0,      3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_lo");
    end
    add(0, 10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "bounce_settle");
    // Auto-repeat: both held, only ch0 enabled. Press at 12, first rpt at
    // 20 (2 ticks), then every tick. Enabling ch1 before 36 joins in.
    add(1, 11, 2'b11, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, "rpt_wait");
    add(0,  1, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00, 2'b00, "rpt_press");
    add(0,  7, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, "rpt_first_gap");
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b01, "rpt_pulse");
      add(0, 3, 2'b11, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00, "rpt_gap");
    end
    add(0, 1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11, "rpt_enable_mid");
    add(0, 3, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, "rpt_after");
    // Tie-break: s drops exactly at the accepting tick (cycle 12) -> no press.
    add(1,  9, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "tie_high");
    add(0, 12, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "tie_fall");
    // One cycle later the same pulse is accepted, then released at 24.
    add(1, 10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "late_high");
    add(0,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "late_fall");
    add(0,  1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b00, "late_press");
    add(0, 11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, "late_wait0");
    add(0,  1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00, "late_release");
    add(0,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "late_idle");

    // Reset state while reset is held.
    @(posedge clk);
    #1;
    check_all("reset_state", 2'b00, 2'b00, 2'b00, 2'b00);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      run_vec(vecs[i].n, vecs[i].btn, vecs[i].en, vecs[i].lvl,
              vecs[i].prs, vecs[i].rls, vecs[i].rp, vecs[i].name);
    end

    // Asynchronous reset in the middle of a hold.
    do_reset();
    run_vec(11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "hold_wait");
    run_vec( 1, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, "hold_press");
    run_vec( 3, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, "hold_level");
    #2;
    reset = 1'b1;
    #1;
    check_all("async_reset", 2'b00, 2'b00, 2'b00, 2'b00);
    @(posedge clk);
    #1;
    check_all("reset_held", 2'b00, 2'b00, 2'b00, 2'b00);
    $display("seq async_reset mid-hold applied, buttons still held");
    reset = 1'b0;
    cyc   = 0;
    // Tick phase restarts: acceptance again lands exactly on cycle 12.
    run_vec(11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, "restart_wait");
    run_vec( 1, 2'b11, 2'b00, 2'b11, 2'b11, 2'b00, 2'b00, "restart_press");
    run_vec( 2, 2'b11, 2'b00, 2'b11, 2'b00, 2'b00, 2'b00, "restart_hold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
